return_stack_ctrl: RTL

Sequencer and arbiter for the CPU return stack. It accepts CALL/RET/CLEAR requests from instruction decode and entry requests from the interrupt controller, with fixed priority. It drives a 1-read/1-write synchronous stack RAM, tracks depth, redirects the program counter, and latches overflow/underflow faults. It sits between decode, the interrupt controller, the stack RAM and the PC mux.

---
 rtl/return_stack_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/return_stack_ctrl.sv
// Return-stack sequencer: arbitrates interrupt entry over decode CALL/RET/CLEAR,
// drives a 1R/1W synchronous stack RAM, redirects the PC and latches stack faults.
module return_stack_ctrl #(
    parameter int PC_WIDTH  = 10,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_op_valid,
    output logic                 o_op_ready,
    input  logic [1:0]           i_op_code,
    input  logic [PC_WIDTH-1:0]  i_op_pc,
    input  logic [PC_WIDTH-1:0]  i_op_target,
    input  logic                 i_irq_valid,
    output logic                 o_irq_ready,
    input  logic [PC_WIDTH-1:0]  i_irq_pc,
    input  logic [PC_WIDTH-1:0]  i_irq_vector,
    output logic                 o_stack_we,
    output logic                 o_stack_re,
    output logic [PTR_WIDTH-1:0] o_stack_addr,
    output logic [PC_WIDTH-1:0]  o_stack_wdata,
    input  logic [PC_WIDTH-1:0]  i_stack_rdata,
    output logic                 o_pc_load,
    output logic [PC_WIDTH-1:0]  o_pc_target,
    output logic [PTR_WIDTH:0]   o_depth,
    output logic                 o_overflow_fault,
    output logic                 o_underflow_fault
);

    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_RET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_READ, S_LOAD, S_FAULT} state_t;

    state_t                r_state, w_next_state;
    logic [PTR_WIDTH:0]    r_depth;
    logic                  r_ovf, r_unf;
    logic [PC_WIDTH-1:0]   r_push_data, r_target;

    logic                  w_idle, w_fault, w_irq_acc, w_op_acc, w_full, w_empty;
    logic [PTR_WIDTH-1:0]  w_top_addr;

    assign w_idle     = (r_state == S_IDLE);
    assign w_fault    = (r_state == S_FAULT);
    assign o_irq_ready = w_idle;
    assign o_op_ready  = (w_idle & ~i_irq_valid) | w_fault;
    assign w_irq_acc  = i_irq_valid & w_idle;
    assign w_op_acc   = i_op_valid & o_op_ready;
    assign w_full     = (r_depth == (PTR_WIDTH+1)'(DEPTH));
    assign w_empty    = (r_depth == '0);
    // At depth DEPTH the low bits are zero, so this wraps to the last entry.
    assign w_top_addr = r_depth[PTR_WIDTH-1:0] - PTR_WIDTH'(1);

    assign o_depth           = r_depth;
    assign o_overflow_fault  = r_ovf;
    assign o_underflow_fault = r_unf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_irq_acc) begin
                    w_next_state = w_full ? S_FAULT : S_PUSH;
                end else if (w_op_acc) begin
                    case (i_op_code)
                        OP_CALL: w_next_state = w_full  ? S_FAULT : S_PUSH;
                        OP_RET:  w_next_state = w_empty ? S_FAULT : S_READ;
                        default: w_next_state = S_IDLE;
                    endcase
                end
            end
            S_PUSH:  w_next_state = S_IDLE;
            S_READ:  w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_IDLE;
            S_FAULT: if (w_op_acc && i_op_code == OP_CLEAR) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_stack_we    = 1'b0;
        o_stack_re    = 1'b0;
        o_stack_addr  = '0;
        o_stack_wdata = '0;
        o_pc_load     = 1'b0;
        o_pc_target   = '0;
        case (r_state)
            S_PUSH: begin
                o_stack_we    = 1'b1;
                o_stack_addr  = r_depth[PTR_WIDTH-1:0];
                o_stack_wdata = r_push_data;
                o_pc_load     = 1'b1;
                o_pc_target   = r_target;
            end
            S_READ: begin
                o_stack_re   = 1'b1;
                o_stack_addr = w_top_addr;
            end
            S_LOAD: begin
                o_pc_load   = 1'b1;
                o_pc_target = i_stack_rdata;
            end
            default: ;
        endcase
    end

    // Operand capture, depth tracking and sticky faults.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_push_data <= '0;
            r_target    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_irq_acc) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_push_data <= i_irq_pc;
                            r_target    <= i_irq_vector;
                        end
                    end else if (w_op_acc) begin
                        case (i_op_code)
                            OP_CALL: begin
                                if (w_full) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_push_data <= i_op_pc + PC_WIDTH'(1);
                                    r_target    <= i_op_target;
                                end
                            end
                            OP_RET:   if (w_empty) r_unf <= 1'b1;
                            OP_CLEAR: begin
                                r_depth <= '0;
                                r_ovf   <= 1'b0;
                                r_unf   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_PUSH: r_depth <= r_depth + (PTR_WIDTH+1)'(1);
                S_LOAD: r_depth <= r_depth - (PTR_WIDTH+1)'(1);
                S_FAULT: begin
                    if (w_op_acc && i_op_code == OP_CLEAR) begin
                        r_depth <= '0;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
